// File: rtl/dice_game_ctrl.sv
// Two-player dice turn controller: debounced buttons, shared roller, score keeping, winner flag.
// Optional feature macro: DICE_DOUBLES_REROLL_EN (a non-winning double grants a bonus turn).
module dice_game_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned TARGET     = 50,
    parameter int unsigned SCORE_W    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_p0,
    input  logic               btn_p1,
    input  logic               new_game,
    input  logic [3:0]         dice1,
    input  logic [3:0]         dice2,
    output logic               roll,
    output logic               active_player,
    output logic               busy,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               winner_valid,
    output logic               winner_id
);
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned WAIT_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;

    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0]   DEB_FIRE  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(SETTLE - 2);
    localparam logic [SCORE_W-1:0] TARGET_S  = SCORE_W'(TARGET);

    typedef enum logic [2:0] {StIdle, StRoll, StWait, StCapture, StDone} state_e;

    state_e             state_q, state_d;
    logic [DEB_W-1:0]   deb0_q, deb0_d, deb1_q, deb1_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d;
    logic               active_q, active_d;
    logic               winner_q, winner_d;

    logic               press0, press1, press_active;
    logic               dice_ok, keep_turn;
    logic [SCORE_W-1:0] sum, cur_score, new_score;

    // Event fires on the sample that takes the counter to DEB_CYCLES.
    assign press0       = btn_p0 && (deb0_q == DEB_FIRE);
    assign press1       = btn_p1 && (deb1_q == DEB_FIRE);
    assign press_active = active_q ? press1 : press0;

    assign deb0_d = !btn_p0 ? '0 : (deb0_q == DEB_MAX) ? deb0_q : deb0_q + 1'b1;
    assign deb1_d = !btn_p1 ? '0 : (deb1_q == DEB_MAX) ? deb1_q : deb1_q + 1'b1;

    assign dice_ok   = (dice1 != 4'd0) && (dice1 <= 4'd6) && (dice2 != 4'd0) && (dice2 <= 4'd6);
    assign sum       = {{(SCORE_W-4){1'b0}}, dice1} + {{(SCORE_W-4){1'b0}}, dice2};
    assign cur_score = active_q ? score1_q : score0_q;
    assign new_score = cur_score + sum;

`ifdef DICE_DOUBLES_REROLL_EN
    assign keep_turn = (dice1 == dice2);
`else
    assign keep_turn = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        score0_d = score0_q;
        score1_d = score1_q;
        active_d = active_q;
        winner_d = winner_q;
        unique case (state_q)
            StIdle: begin
                if (press_active) state_d = StRoll;
            end
            StRoll: begin
                wait_d  = '0;
                state_d = (SETTLE > 1) ? StWait : StCapture;
            end
            StWait: begin
                if (wait_q == WAIT_LAST) state_d = StCapture;
                else                     wait_d  = wait_q + 1'b1;
            end
            StCapture: begin
                if (!dice_ok) begin
                    state_d = StRoll;
                end else begin
                    if (active_q) score1_d = new_score;
                    else          score0_d = new_score;
                    if (new_score >= TARGET_S) begin
                        winner_d = active_q;
                        state_d  = StDone;
                    end else begin
                        if (!keep_turn) active_d = !active_q;
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                if (new_game) begin
                    score0_d = '0;
                    score1_d = '0;
                    active_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            deb0_q   <= '0;
            deb1_q   <= '0;
            wait_q   <= '0;
            score0_q <= '0;
            score1_q <= '0;
            active_q <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            deb0_q   <= deb0_d;
            deb1_q   <= deb1_d;
            wait_q   <= wait_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            active_q <= active_d;
            winner_q <= winner_d;
        end
    end

    assign roll          = (state_q == StRoll);
    assign busy          = (state_q == StRoll) || (state_q == StWait) || (state_q == StCapture);
    assign winner_valid  = (state_q == StDone);
    assign active_player = active_q;
    assign winner_id     = winner_q;
    assign score0        = score0_q;
    assign score1        = score1_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Bench for dice_game_ctrl: directed game scenarios plus random play against a turn-level model.
module tb_dice_game_ctrl;
    localparam int DEB = 4;
    localparam int SET = 2;
    localparam int TGT = 50;
    localparam int SW  = 7;
`ifdef DICE_DOUBLES_REROLL_EN
    localparam bit DOUBLES = 1'b1;
`else
    localparam bit DOUBLES = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_p0 = 1'b0, btn_p1 = 1'b0, new_game = 1'b0;
    logic [3:0]    dice1 = 4'd1, dice2 = 4'd1;
    logic          roll, active_player, busy, winner_valid, winner_id;
    logic [SW-1:0] score0, score1;

    int n_vec = 0;
    int n_err = 0;
    int roll_cnt = 0;

    // Reference model: m_t is cycles since the roll cycle (-1 when not rolling).
    int m_score[2];
    int m_act, m_t, m_win;
    bit m_done, m_win_ok;
    int streak[2];

    always #5 clk = ~clk;

    dice_game_ctrl #(
        .DEB_CYCLES(DEB), .SETTLE(SET), .TARGET(TGT), .SCORE_W(SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_p0       (btn_p0),
        .btn_p1       (btn_p1),
        .new_game     (new_game),
        .dice1        (dice1),
        .dice2        (dice2),
        .roll         (roll),
        .active_player(active_player),
        .busy         (busy),
        .score0       (score0),
        .score1       (score1),
        .winner_valid (winner_valid),
        .winner_id    (winner_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ev0, ev1;
        int d1, d2;
        if (!rst_n) begin
            m_score[0] = 0; m_score[1] = 0;
            m_act = 0; m_t = -1; m_win = 0;
            m_done = 1'b0; m_win_ok = 1'b1;
            streak[0] = 0; streak[1] = 0;
            return;
        end
        ev0 = btn_p0 && (streak[0] == DEB - 1);
        ev1 = btn_p1 && (streak[1] == DEB - 1);
        streak[0] = btn_p0 ? streak[0] + 1 : 0;
        streak[1] = btn_p1 ? streak[1] + 1 : 0;
        d1 = int'(dice1);
        d2 = int'(dice2);
        if (m_done) begin
            if (new_game) begin
                m_score[0] = 0; m_score[1] = 0;
                m_act = 0; m_done = 1'b0; m_win_ok = 1'b0;
            end
        end else if (m_t < 0) begin
            if ((m_act == 0) ? ev0 : ev1) m_t = 0;
        end else if (m_t < SET) begin
            m_t++;
        end else if (d1 < 1 || d1 > 6 || d2 < 1 || d2 > 6) begin
            m_t = 0;
        end else begin
            m_t = -1;
            m_score[m_act] += d1 + d2;
            if (m_score[m_act] >= TGT) begin
                m_done = 1'b1; m_win = m_act; m_win_ok = 1'b1;
            end else if (!(DOUBLES && d1 == d2)) begin
                m_act = 1 - m_act;
            end
        end
    endtask

    task automatic compare_all();
        check("roll", roll, (m_t == 0));
        check("busy", busy, (m_t >= 0));
        check("active_player", active_player, m_act);
        check("score0", score0, m_score[0]);
        check("score1", score1, m_score[1]);
        check("winner_valid", winner_valid, m_done);
        if (m_win_ok) check("winner_id", winner_id, m_win);
    endtask

    // One clock: model consumes inputs at the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (roll === 1'b1) roll_cnt++;
    endtask

    task automatic take_turn(input int d1, input int d2);
        dice1 = 4'(d1);
        dice2 = 4'(d2);
        if (m_act == 0) btn_p0 = 1'b1; else btn_p1 = 1'b1;
        repeat (DEB) cycle();
        btn_p0 = 1'b0;
        btn_p1 = 1'b0;
        repeat (SET + 3) cycle();
    endtask

    initial begin
        int r, a, b;
        rst_n = 1'b0;
        repeat (2) cycle();
        check("rst_score0", score0, 0);
        check("rst_active", active_player, 0);
        rst_n = 1'b1;
        cycle();

        // Held button yields one roll, however long it is held.
        dice1 = 4'd1; dice2 = 4'd2;
        roll_cnt = 0;
        btn_p0 = 1'b1; repeat (DEB) cycle(); btn_p0 = 1'b0;
        repeat (6) cycle();
        check("t1_hold4_rolls", roll_cnt, 1);
        roll_cnt = 0;
        btn_p1 = 1'b1; repeat (20) cycle(); btn_p1 = 1'b0;
        repeat (3) cycle();
        check("t1_hold20_rolls", roll_cnt, 1);

        // Off-turn player cannot roll.
        roll_cnt = 0;
        btn_p1 = 1'b1; repeat (10) cycle(); btn_p1 = 1'b0;
        repeat (3) cycle();
        check("t2_no_roll", roll_cnt, 0);
        check("t2_active", active_player, 0);

        take_turn(3, 4);
        check("t3_score0", score0, 10);
        check("t3_active", active_player, 1);

        // Invalid die forces an automatic re-roll, then a double is scored.
        roll_cnt = 0;
        dice1 = 4'd0; dice2 = 4'd5;
        btn_p1 = 1'b1; repeat (DEB) cycle(); btn_p1 = 1'b0;
        repeat (8) cycle();
        check("t4_reroll", (roll_cnt >= 2), 1);
        dice1 = 4'd2; dice2 = 4'd2;
        repeat (6) cycle();
        check("t4_score1", score1, 7);
        check("t4_active", active_player, DOUBLES ? 1 : 0);

        // Bring player 1 to 45, then win with 3,3.
        for (int i = 0; i < 30 && m_score[1] < 45; i++) begin
            if (m_act == 0) begin
                take_turn(1, 2);
            end else begin
                r = 45 - m_score[1];
                if (r >= 12) begin a = 6; b = 5; end
                else begin a = r / 2; b = r - a; end
                take_turn(a, b);
            end
        end
        if (m_act == 0) take_turn(1, 2);
        check("t5_pre_score1", score1, 45);
        take_turn(3, 3);
        check("t5_score1", score1, 51);
        check("t5_winner_valid", winner_valid, 1);
        check("t5_winner_id", winner_id, 1);
        roll_cnt = 0;
        btn_p0 = 1'b1; btn_p1 = 1'b1; repeat (10) cycle(); btn_p0 = 1'b0; btn_p1 = 1'b0;
        cycle();
        check("t5_done_no_roll", roll_cnt, 0);
        new_game = 1'b1; cycle(); new_game = 1'b0;
        cycle();
        check("t5_ng_score1", score1, 0);
        check("t5_ng_active", active_player, 0);
        check("t5_ng_valid", winner_valid, 0);

        // Reset during the settle wait aborts the roll.
        dice1 = 4'd6; dice2 = 4'd5;
        btn_p0 = 1'b1; repeat (DEB) cycle(); btn_p0 = 1'b0;
        cycle();
        check("t6_busy_wait", busy, 1);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        check("t6_roll", roll, 0);
        check("t6_busy", busy, 0);
        repeat (6) cycle();
        check("t6_no_capture", score0, 0);

        // Random play.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 5) == 0) btn_p0 = ~btn_p0;
            if ($urandom_range(0, 5) == 0) btn_p1 = ~btn_p1;
            if ($urandom_range(0, 9) == 0) begin
                dice1 = 4'($urandom_range(0, 15));
                dice2 = 4'($urandom_range(0, 7));
            end else begin
                dice1 = 4'($urandom_range(1, 6));
                dice2 = 4'($urandom_range(1, 6));
            end
            new_game = ($urandom_range(0, 19) == 0);
            rst_n    = ($urandom_range(0, 1999) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
